gpio_bank: RTL and testbench

- Parametrised memory-mapped GPIO peripheral; the successor to the fixed LED/button registers on the SoC memory bus.
- WIDTH pins, each with a direction bit, an output register, a synchronised input, per-bit rising/falling edge detection and a sticky interrupt-pending register with a single OR'd interrupt output.
- Sits on the common memory bus behind the top-level address decoder. It sees word offsets via address_in[4:2] and returns zero read data when not selected, so its read value can be OR'd onto the shared bus.

---
 rtl/gpio_pkg.sv | 20 ++
 rtl/gpio_debounce.sv | 30 +++
 rtl/gpio_bank.sv | 130 +++++++++++++
 tb/tb_gpio_bank.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_pkg.sv
// Shared definitions for the gpio_bank peripheral: register indices and
// byte-lane helper. Optional input debounce is enabled by GPIO_DEBOUNCE_EN.
package gpio_pkg;

    typedef logic [2:0] gpio_reg_t;

    localparam gpio_reg_t GPIO_OUT  = 3'd0;
    localparam gpio_reg_t GPIO_IN   = 3'd1;
    localparam gpio_reg_t GPIO_DIR  = 3'd2;
    localparam gpio_reg_t GPIO_RISE = 3'd3;
    localparam gpio_reg_t GPIO_FALL = 3'd4;
    localparam gpio_reg_t GPIO_PEND = 3'd5;
    localparam gpio_reg_t GPIO_SET  = 3'd6;
    localparam gpio_reg_t GPIO_CLR  = 3'd7;

    function automatic logic [31:0] lane_mask(input logic [3:0] m);
        return {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
    endfunction

endpackage

// File: rtl/gpio_debounce.sv
// Single-bit input debouncer: v follows s2 only after s2 has differed
// from v for 2^DEBOUNCE_BITS-1 consecutive cycles (used with GPIO_DEBOUNCE_EN).
module gpio_debounce #(
    parameter int DEBOUNCE_BITS = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic s2,
    output logic v
);

    localparam logic [DEBOUNCE_BITS-1:0] CNT_MAX = '1;

    logic [DEBOUNCE_BITS-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
            v   <= 1'b0;
        end else if (s2 == v) begin
            cnt <= '0;
        end else if (cnt == CNT_MAX) begin
            cnt <= '0;
            v   <= s2;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/gpio_bank.sv
// Memory-mapped GPIO bank: output/direction registers, synchronised inputs,
// edge-triggered sticky interrupts. Define GPIO_DEBOUNCE_EN for input debounce.
module gpio_bank
    import gpio_pkg::*;
#(
    parameter int WIDTH         = 8,
    parameter int DEBOUNCE_BITS = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      address_in,
    input  logic             sel_in,
    input  logic             read_in,
    output logic [31:0]      read_value_out,
    input  logic [3:0]       write_mask_in,
    input  logic [31:0]      write_value_in,
    output logic             ready_out,
    input  logic [WIDTH-1:0] gpio_in,
    output logic [WIDTH-1:0] gpio_out,
    output logic [WIDTH-1:0] gpio_oe,
    output logic             irq_out
);

    gpio_reg_t        idx;
    logic             wr;
    logic [31:0]      lane;
    logic [WIDTH-1:0] bm;
    logic [WIDTH-1:0] wv;
    logic [WIDTH-1:0] w1c;

    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] dir_q;
    logic [WIDTH-1:0] rise_en_q;
    logic [WIDTH-1:0] fall_en_q;
    logic [WIDTH-1:0] pend_q;

    logic [WIDTH-1:0] s1;
    logic [WIDTH-1:0] s2;
    logic [WIDTH-1:0] v;
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;

    logic [31:0]      rd;
    logic             unused_bits;

    assign idx  = address_in[4:2];
    assign wr   = sel_in && (write_mask_in != 4'b0000);
    assign lane = lane_mask(write_mask_in);
    assign bm   = lane[WIDTH-1:0];
    assign wv   = write_value_in[WIDTH-1:0] & bm;
    assign w1c  = (wr && idx == GPIO_PEND) ? wv : '0;

    assign rise = v & ~p & rise_en_q;
    assign fall = ~v & p & fall_en_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_q     <= '0;
            dir_q     <= '0;
            rise_en_q <= '0;
            fall_en_q <= '0;
            pend_q    <= '0;
            s1        <= '0;
            s2        <= '0;
            p         <= '0;
        end else begin
            s1     <= gpio_in;
            s2     <= s1;
            p      <= v;
            // New edges take priority over a same-cycle clear
            pend_q <= (pend_q & ~w1c) | rise | fall;
            if (wr) begin
                case (idx)
                    GPIO_OUT:  out_q     <= (out_q & ~bm) | wv;
                    GPIO_DIR:  dir_q     <= (dir_q & ~bm) | wv;
                    GPIO_RISE: rise_en_q <= (rise_en_q & ~bm) | wv;
                    GPIO_FALL: fall_en_q <= (fall_en_q & ~bm) | wv;
                    GPIO_SET:  out_q     <= out_q | wv;
                    GPIO_CLR:  out_q     <= out_q & ~wv;
                    default: ;
                endcase
            end
        end
    end

`ifdef GPIO_DEBOUNCE_EN
    for (genvar i = 0; i < WIDTH; i++) begin : g_db
        gpio_debounce #(
            .DEBOUNCE_BITS(DEBOUNCE_BITS)
        ) u_db (
            .clk  (clk),
            .reset(reset),
            .s2   (s2[i]),
            .v    (v[i])
        );
    end
`else
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) v <= '0;
        else        v <= s2;
    end
`endif

    always_comb begin
        rd = '0;
        if (sel_in) begin
            case (idx)
                GPIO_OUT:  rd[WIDTH-1:0] = out_q;
                GPIO_IN:   rd[WIDTH-1:0] = v;
                GPIO_DIR:  rd[WIDTH-1:0] = dir_q;
                GPIO_RISE: rd[WIDTH-1:0] = rise_en_q;
                GPIO_FALL: rd[WIDTH-1:0] = fall_en_q;
                GPIO_PEND: rd[WIDTH-1:0] = pend_q;
                default:   rd = '0;
            endcase
        end
    end

    assign read_value_out = rd;
    assign ready_out      = sel_in;
    assign gpio_out       = out_q;
    assign gpio_oe        = dir_q;
    assign irq_out        = |pend_q;

    // Read data does not depend on the strobe; the bus ORs unselected zeros
    assign unused_bits = ^{read_in, address_in[31:5], address_in[1:0],
                           write_value_in, lane, (DEBOUNCE_BITS != 0)};

endmodule

// File: tb/tb_gpio_bank.sv
// Directed self-checking bench for gpio_bank (WIDTH=8 and WIDTH=4 copies).
// Debounce checks run only when GPIO_DEBOUNCE_EN is defined.
module tb_gpio_bank;

`ifdef GPIO_DEBOUNCE_EN
    localparam int IN_LAT = 17;
`else
    localparam int IN_LAT = 2;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic        rd_en;
    logic        sel8;
    logic        sel4;
    logic [31:0] rd8;
    logic [31:0] rd4;
    logic        ready8;
    logic        ready4;
    logic [7:0]  gin;
    logic [7:0]  gout8;
    logic [7:0]  goe8;
    logic        irq8;
    logic [3:0]  gin4;
    logic [3:0]  gout4;
    logic [3:0]  goe4;
    logic        irq4;
    logic [31:0] d;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    gpio_bank #(.WIDTH(8), .DEBOUNCE_BITS(4)) u_dut (
        .clk           (clk),
        .reset         (rst_n),
        .address_in    (addr),
        .sel_in        (sel8),
        .read_in       (rd_en),
        .read_value_out(rd8),
        .write_mask_in (wmask),
        .write_value_in(wdata),
        .ready_out     (ready8),
        .gpio_in       (gin),
        .gpio_out      (gout8),
        .gpio_oe       (goe8),
        .irq_out       (irq8)
    );

    gpio_bank #(.WIDTH(4), .DEBOUNCE_BITS(4)) u_w4 (
        .clk           (clk),
        .reset         (rst_n),
        .address_in    (addr),
        .sel_in        (sel4),
        .read_in       (rd_en),
        .read_value_out(rd4),
        .write_mask_in (wmask),
        .write_value_in(wdata),
        .ready_out     (ready4),
        .gpio_in       (gin4),
        .gpio_out      (gout4),
        .gpio_oe       (goe4),
        .irq_out       (irq4)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic bus_wr(input bit w4, input logic [2:0] idx,
                          input logic [31:0] dv, input logic [3:0] m);
        addr  = {27'd0, idx, 2'b00};
        wdata = dv;
        wmask = m;
        if (w4) sel4 = 1'b1;
        else    sel8 = 1'b1;
        @(posedge clk);
        #1;
        sel8  = 1'b0;
        sel4  = 1'b0;
        wmask = 4'h0;
        @(negedge clk);
    endtask

    task automatic bus_rd(input bit w4, input logic [2:0] idx,
                          output logic [31:0] dv);
        addr  = {27'd0, idx, 2'b00};
        rd_en = 1'b1;
        if (w4) sel4 = 1'b1;
        else    sel8 = 1'b1;
        #1;
        dv    = w4 ? rd4 : rd8;
        #1;
        sel8  = 1'b0;
        sel4  = 1'b0;
        rd_en = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        addr  = '0;
        wdata = '0;
        wmask = '0;
        rd_en = 1'b0;
        sel8  = 1'b0;
        sel4  = 1'b0;
        gin   = '0;
        gin4  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_gout", {24'd0, gout8}, 32'h0);
        chk("rst_goe", {24'd0, goe8}, 32'h0);
        chk("rst_irq", {31'd0, irq8}, 32'h0);
        chk("rst_ready", {31'd0, ready8}, 32'h0);
        rst_n = 1'b1;
        cyc(2);

        bus_wr(0, 3'd0, 32'h0000_00A5, 4'b0001);
        bus_wr(0, 3'd2, 32'h0000_00FF, 4'b0001);
        chk("gpio_out", {24'd0, gout8}, 32'hA5);
        chk("gpio_oe", {24'd0, goe8}, 32'hFF);
        addr = 32'h0;
        sel8 = 1'b1;
        #1;
        chk("ready_sel", {31'd0, ready8}, 32'h1);
        chk("rd_out", rd8, 32'hA5);
        sel8 = 1'b0;
        #1;
        chk("ready_idle", {31'd0, ready8}, 32'h0);
        chk("rd_unsel", rd8, 32'h0);

        bus_wr(0, 3'd6, 32'h0000_000F, 4'b1111);
        bus_wr(0, 3'd7, 32'h0000_0081, 4'b1111);
        bus_rd(0, 3'd0, d); chk("set_clr_out", d, 32'h2E);
        bus_rd(0, 3'd6, d); chk("rd_set", d, 32'h0);
        bus_rd(0, 3'd7, d); chk("rd_clr", d, 32'h0);
        bus_wr(0, 3'd0, 32'h0000_0011, 4'b0010);
        bus_rd(0, 3'd0, d); chk("lane_gate", d, 32'h2E);

        bus_wr(0, 3'd3, 32'h0000_0001, 4'b0001);
        gin[0] = 1'b1;
        cyc(IN_LAT);
        bus_rd(0, 3'd1, d); chk("in_early", d, 32'h0);
        cyc(1);
        bus_rd(0, 3'd1, d); chk("in_rise", d, 32'h1);
        bus_rd(0, 3'd5, d); chk("pend_early", d, 32'h0);
        cyc(1);
        bus_rd(0, 3'd5, d); chk("pend_rise", d, 32'h1);
        chk("irq_rise", {31'd0, irq8}, 32'h1);
        bus_wr(0, 3'd5, 32'h0000_0001, 4'b0001);
        chk("irq_w1c", {31'd0, irq8}, 32'h0);

        bus_wr(0, 3'd4, 32'h0000_0002, 4'b0001);
        gin[1] = 1'b1;
        cyc(IN_LAT + 3);
        bus_rd(0, 3'd5, d); chk("pend_no_rise1", d, 32'h0);
        gin[1] = 1'b0;
        cyc(IN_LAT + 3);
        bus_rd(0, 3'd5, d); chk("pend_fall", d, 32'h2);
        gin[1] = 1'b1;
        cyc(IN_LAT + 3);
        gin[1] = 1'b0;
        cyc(IN_LAT + 1);
        bus_wr(0, 3'd5, 32'h0000_0002, 4'b0001);
        bus_rd(0, 3'd5, d); chk("pend_set_wins", d, 32'h2);
        bus_wr(0, 3'd5, 32'h0000_0002, 4'b0001);
        bus_rd(0, 3'd5, d); chk("pend_cleared", d, 32'h0);

        gin[3] = 1'b1;
        cyc(IN_LAT + 3);
        bus_wr(0, 3'd3, 32'h0000_0009, 4'b0001);
        cyc(IN_LAT + 3);
        bus_rd(0, 3'd5, d); chk("en_while_high", d, 32'h0);
        gin[3] = 1'b0;
        cyc(IN_LAT + 3);
        gin[3] = 1'b1;
        cyc(IN_LAT + 3);
        bus_wr(0, 3'd3, 32'h0000_0001, 4'b0001);
        cyc(2);
        bus_rd(0, 3'd5, d); chk("pend_keep", d, 32'h8);
        chk("irq_keep", {31'd0, irq8}, 32'h1);
        bus_rd(0, 3'd3, d); chk("rd_rise_en", d, 32'h1);
        bus_rd(0, 3'd4, d); chk("rd_fall_en", d, 32'h2);
        bus_rd(0, 3'd1, d); chk("in_any_dir", d, 32'h9);

        bus_wr(1, 3'd0, 32'hFFFF_FFFF, 4'b1111);
        bus_rd(1, 3'd0, d); chk("w4_out", d, 32'hF);
        chk("w4_gout", {28'd0, gout4}, 32'hF);
        bus_rd(0, 3'd0, d); chk("w8_untouched", d, 32'h2E);

        addr  = 32'h0;
        wdata = 32'h0000_0055;
        wmask = 4'b0001;
        sel8  = 1'b1;
        #2;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        sel8  = 1'b0;
        wmask = 4'h0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("mid_gout", {24'd0, gout8}, 32'h0);
        chk("mid_goe", {24'd0, goe8}, 32'h0);
        chk("mid_irq", {31'd0, irq8}, 32'h0);
        bus_rd(0, 3'd0, d); chk("mid_out", d, 32'h0);
        cyc(IN_LAT + 4);
        bus_rd(0, 3'd5, d); chk("rel_high_pend", d, 32'h0);
        bus_rd(0, 3'd1, d); chk("rel_high_in", d, 32'h9);

`ifdef GPIO_DEBOUNCE_EN
        bus_wr(0, 3'd3, 32'h0000_0004, 4'b0001);
        bus_wr(0, 3'd4, 32'h0000_0004, 4'b0001);
        gin[2] = 1'b1;
        cyc(10);
        gin[2] = 1'b0;
        cyc(25);
        bus_rd(0, 3'd1, d); chk("db_glitch_in", d & 32'h4, 32'h0);
        bus_rd(0, 3'd5, d); chk("db_glitch_pend", d, 32'h0);
        gin[2] = 1'b1;
        cyc(IN_LAT);
        bus_rd(0, 3'd1, d); chk("db_level_early", d & 32'h4, 32'h0);
        cyc(1);
        bus_rd(0, 3'd1, d); chk("db_level_in", d & 32'h4, 32'h4);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
